// File: rtl/alu_writeback_if.sv
// Bundles the ALU-to-writeback handshake, the two operand read ports and the status outputs.
// The upstream/operand-fetch side uses master; the writeback stage uses slave.
interface alu_writeback_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opcode;
    logic [3:0]        in_dest;
    logic [DATA_W-1:0] in_out;
    logic [DATA_W-1:0] in_r15;
    logic              in_neg;
    logic              in_zero;
    logic              in_error;
    logic [3:0]        rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [3:0]        rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              flag_neg;
    logic              flag_zero;
    logic              flag_error;
    logic              wb_busy;

    modport master (
        output in_valid, in_opcode, in_dest, in_out, in_r15,
               in_neg, in_zero, in_error, rd_addr_a, rd_addr_b,
        input  in_ready, rd_data_a, rd_data_b,
               flag_neg, flag_zero, flag_error, wb_busy
    );

    modport slave (
        input  in_valid, in_opcode, in_dest, in_out, in_r15,
               in_neg, in_zero, in_error, rd_addr_a, rd_addr_b,
        output in_ready, rd_data_a, rd_data_b,
               flag_neg, flag_zero, flag_error, wb_busy
    );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: commits one result per handshake into a 16-entry register file,
// spending a second cycle on the HI_REG write for mul/div, with two write-first read ports.
module alu_writeback #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned HI_REG  = 15,
    parameter int unsigned R0_ZERO = 1
) (
    input  logic           clk,
    input  logic           rst,
    alu_writeback_if.slave wb
);
    localparam logic [3:0] HI_ADDR = 4'(HI_REG);
    localparam bit         R0_EN   = (R0_ZERO != 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WR_HI = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [2:0]        flags_q, flags_d;   // {neg, zero, error}

    logic              ready;
    logic              accept;
    logic              is_muldiv;
    logic              conflict;
    logic              we;
    logic [3:0]        waddr;
    logic [DATA_W-1:0] wdata;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        flags_d   = flags_q;
        ready     = 1'b0;
        accept    = 1'b0;
        we        = 1'b0;
        waddr     = wb.in_dest;
        wdata     = wb.in_out;
        is_muldiv = (wb.in_opcode == 4'b0100) || (wb.in_opcode == 4'b0101);
        conflict  = is_muldiv && (wb.in_dest == HI_ADDR);

        case (state_q)
            IDLE: begin
                ready  = ~rst;
                accept = wb.in_valid & ready;
                if (accept) begin
                    we      = 1'b1;
                    flags_d = {wb.in_neg, wb.in_zero, wb.in_error | conflict};
                    // A two-word result aimed at HI_REG keeps the primary word only.
                    if (is_muldiv && !conflict) begin
                        hi_d    = wb.in_r15;
                        state_d = WR_HI;
                    end
                end
            end
            WR_HI: begin
                we      = ~rst;
                waddr   = HI_ADDR;
                wdata   = hi_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (R0_EN && (waddr == 4'd0)) begin
            we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            flags_q <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
            if (we) begin
                regs_q[waddr] <= wdata;
            end
        end
    end

    // Write-first bypass so operand fetch sees a result in the cycle it is committed.
    always_comb begin
        if (R0_EN && (wb.rd_addr_a == 4'd0)) begin
            wb.rd_data_a = '0;
        end else if (we && (wb.rd_addr_a == waddr)) begin
            wb.rd_data_a = wdata;
        end else begin
            wb.rd_data_a = regs_q[wb.rd_addr_a];
        end
    end

    always_comb begin
        if (R0_EN && (wb.rd_addr_b == 4'd0)) begin
            wb.rd_data_b = '0;
        end else if (we && (wb.rd_addr_b == waddr)) begin
            wb.rd_data_b = wdata;
        end else begin
            wb.rd_data_b = regs_q[wb.rd_addr_b];
        end
    end

    assign wb.in_ready   = ready;
    assign wb.wb_busy    = (state_q == WR_HI);
    assign wb.flag_neg   = flags_q[2];
    assign wb.flag_zero  = flags_q[1];
    assign wb.flag_error = flags_q[0];
endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios plus randomized traffic against a queue-based
// reference model, on one instance with R0 hardwired to zero and one with an ordinary R0.
module tb_alu_writeback;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [3:0]  opc = '0, dest = '0, ra = '0, rb = '0;
    logic [15:0] out = '0, r15 = '0;
    logic        neg = 1'b0, zero = 1'b0, err = 1'b0;

    int total = 0;
    int bad = 0;

    // Reference model: register images for both R0 modes, pending high-word writes, flags.
    logic [15:0] m1 [16];
    logic [15:0] m0 [16];
    logic [15:0] pend [$];
    logic [2:0]  mflags;

    always #5 clk = ~clk;

    alu_writeback_if #(.DATA_W(16)) bus1 ();
    alu_writeback_if #(.DATA_W(16)) bus0 ();

    assign bus1.in_valid = valid;  assign bus0.in_valid = valid;
    assign bus1.in_opcode = opc;   assign bus0.in_opcode = opc;
    assign bus1.in_dest = dest;    assign bus0.in_dest = dest;
    assign bus1.in_out = out;      assign bus0.in_out = out;
    assign bus1.in_r15 = r15;      assign bus0.in_r15 = r15;
    assign bus1.in_neg = neg;      assign bus0.in_neg = neg;
    assign bus1.in_zero = zero;    assign bus0.in_zero = zero;
    assign bus1.in_error = err;    assign bus0.in_error = err;
    assign bus1.rd_addr_a = ra;    assign bus0.rd_addr_a = ra;
    assign bus1.rd_addr_b = rb;    assign bus0.rd_addr_b = rb;

    alu_writeback #(.DATA_W(16), .HI_REG(15), .R0_ZERO(1)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus1)
    );

    alu_writeback #(.DATA_W(16), .HI_REG(15), .R0_ZERO(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .wb  (bus0)
    );

    function automatic logic exp_ready();
        return !rst && (pend.size() == 0);
    endfunction

    function automatic logic [15:0] exp_rd(input logic [3:0] a, input bit r0z);
        if (r0z && a == 4'd0) return 16'h0000;
        if (!rst) begin
            if (pend.size() > 0) begin
                if (a == 4'd15) return pend[0];
            end else if (valid && !(r0z && dest == 4'd0) && a == dest) begin
                return out;
            end
        end
        return r0z ? m1[a] : m0[a];
    endfunction

    task automatic model_step();
        logic [15:0] v;
        bit md;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m1[i] = '0;
                m0[i] = '0;
            end
            pend.delete();
            mflags = '0;
        end else if (pend.size() > 0) begin
            v = pend.pop_front();
            m1[15] = v;
            m0[15] = v;
        end else if (valid) begin
            if (dest != 4'd0) m1[dest] = out;
            m0[dest] = out;
            md = (opc == 4'b0100) || (opc == 4'b0101);
            mflags = {neg, zero, err | (md && dest == 4'd15)};
            if (md && dest != 4'd15) pend.push_back(r15);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0;
        #1;
        total++;
        if (bus1.in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0: got %b want 0", bus1.in_ready); end
        tick();
        #1;
        total++;
        if (bus1.in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1: got %b want 0", bus1.in_ready); end
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (bus1.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", bus1.in_ready); end
        total++;
        if ({bus1.flag_neg, bus1.flag_zero, bus1.flag_error} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {bus1.flag_neg, bus1.flag_zero, bus1.flag_error});
        end
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i); rb = 4'(15 - i);
            #1;
            total++;
            if (bus1.rd_data_a !== 16'h0 || bus0.rd_data_b !== 16'h0) begin
                bad++; $display("FAIL reset_reg%0d: got %h/%h want 0000/0000", i, bus1.rd_data_a, bus0.rd_data_b);
            end
            tick();
        end
    endtask

    task automatic test_add();
        valid = 1'b1; opc = 4'b0000; dest = 4'd3; out = 16'h0007; r15 = 16'hBEEF;
        neg = 1'b0; zero = 1'b0; err = 1'b1; ra = 4'd3; rb = 4'd15;
        #1;
        total++;
        if (bus1.rd_data_a !== 16'h0007) begin bad++; $display("FAIL add_bypass: got %h want 0007", bus1.rd_data_a); end
        total++;
        if (bus1.rd_data_b !== 16'h0000) begin bad++; $display("FAIL add_r15_bypass: got %h want 0000", bus1.rd_data_b); end
        tick();
        valid = 1'b0;
        #1;
        total++;
        if ({bus1.flag_neg, bus1.flag_zero, bus1.flag_error} !== 3'b001) begin
            bad++; $display("FAIL add_flags: got %b want 001", {bus1.flag_neg, bus1.flag_zero, bus1.flag_error});
        end
        total++;
        if (bus1.in_ready !== 1'b1 || bus1.wb_busy !== 1'b0) begin
            bad++; $display("FAIL add_ready: got rdy=%b busy=%b want 1/0", bus1.in_ready, bus1.wb_busy);
        end
        total++;
        if (bus1.rd_data_a !== 16'h0007 || bus1.rd_data_b !== 16'h0000) begin
            bad++; $display("FAIL add_array: got %h/%h want 0007/0000", bus1.rd_data_a, bus1.rd_data_b);
        end
        tick();
    endtask

    task automatic test_mul();
        valid = 1'b1; opc = 4'b0100; dest = 4'd2; out = 16'h5678; r15 = 16'h1234;
        neg = 1'b1; zero = 1'b0; err = 1'b0; ra = 4'd2; rb = 4'd15;
        #1;
        total++;
        if (bus1.rd_data_a !== 16'h5678 || bus1.in_ready !== 1'b1) begin
            bad++; $display("FAIL mul_accept: got %h rdy=%b want 5678 rdy=1", bus1.rd_data_a, bus1.in_ready);
        end
        tick();
        // Upstream presents an add while the stage is busy; it must wait.
        opc = 4'b0000; dest = 4'd4; out = 16'h00AA; neg = 1'b0;
        ra = 4'd15; rb = 4'd4;
        #1;
        total++;
        if (bus1.in_ready !== 1'b0 || bus1.wb_busy !== 1'b1) begin
            bad++; $display("FAIL mul_wrhi: got rdy=%b busy=%b want 0/1", bus1.in_ready, bus1.wb_busy);
        end
        total++;
        if (bus1.rd_data_a !== 16'h1234 || bus1.rd_data_b !== 16'h0000) begin
            bad++; $display("FAIL mul_hi_bypass: got %h/%h want 1234/0000", bus1.rd_data_a, bus1.rd_data_b);
        end
        tick();
        #1;
        total++;
        if (bus1.in_ready !== 1'b1 || bus1.wb_busy !== 1'b0) begin
            bad++; $display("FAIL mul_back_idle: got rdy=%b busy=%b want 1/0", bus1.in_ready, bus1.wb_busy);
        end
        total++;
        if (bus1.rd_data_a !== 16'h1234 || bus1.rd_data_b !== 16'h00AA) begin
            bad++; $display("FAIL mul_held_add: got %h/%h want 1234/00aa", bus1.rd_data_a, bus1.rd_data_b);
        end
        total++;
        if ({bus1.flag_neg, bus1.flag_zero, bus1.flag_error} !== 3'b100) begin
            bad++; $display("FAIL mul_flags: got %b want 100", {bus1.flag_neg, bus1.flag_zero, bus1.flag_error});
        end
        tick();
        valid = 1'b0;
        #1;
        total++;
        if ({bus1.flag_neg, bus1.flag_zero, bus1.flag_error} !== 3'b000 || bus1.rd_data_b !== 16'h00AA) begin
            bad++; $display("FAIL mul_after_add: got flags=%b rd=%h want 000/00aa",
                            {bus1.flag_neg, bus1.flag_zero, bus1.flag_error}, bus1.rd_data_b);
        end
        tick();
    endtask

    task automatic test_conflict();
        valid = 1'b1; opc = 4'b0101; dest = 4'd15; out = 16'h0003; r15 = 16'h0001;
        neg = 1'b0; zero = 1'b0; err = 1'b0; ra = 4'd15;
        #1;
        total++;
        if (bus1.rd_data_a !== 16'h0003) begin bad++; $display("FAIL conflict_bypass: got %h want 0003", bus1.rd_data_a); end
        tick();
        valid = 1'b0;
        #1;
        total++;
        if (bus1.in_ready !== 1'b1 || bus1.wb_busy !== 1'b0) begin
            bad++; $display("FAIL conflict_no_wrhi: got rdy=%b busy=%b want 1/0", bus1.in_ready, bus1.wb_busy);
        end
        total++;
        if (bus1.flag_error !== 1'b1 || bus1.rd_data_a !== 16'h0003) begin
            bad++; $display("FAIL conflict_result: got err=%b r15=%h want 1/0003", bus1.flag_error, bus1.rd_data_a);
        end
        tick();
        #1;
        total++;
        if (bus1.rd_data_a !== 16'h0003) begin bad++; $display("FAIL conflict_r15_kept: got %h want 0003", bus1.rd_data_a); end
        tick();
    endtask

    task automatic test_r0();
        valid = 1'b1; opc = 4'b0000; dest = 4'd0; out = 16'hFFFF; ra = 4'd0;
        #1;
        total++;
        if (bus1.rd_data_a !== 16'h0000 || bus0.rd_data_a !== 16'hFFFF) begin
            bad++; $display("FAIL r0_bypass: got %h/%h want 0000/ffff", bus1.rd_data_a, bus0.rd_data_a);
        end
        tick();
        valid = 1'b0;
        #1;
        total++;
        if (bus1.rd_data_a !== 16'h0000 || bus0.rd_data_a !== 16'hFFFF) begin
            bad++; $display("FAIL r0_array: got %h/%h want 0000/ffff", bus1.rd_data_a, bus0.rd_data_a);
        end
        tick();
    endtask

    task automatic test_reset_wrhi();
        valid = 1'b1; opc = 4'b0100; dest = 4'd2; out = 16'h1111; r15 = 16'h1234;
        tick();
        valid = 1'b0; rst = 1'b1;
        #1;
        total++;
        if (bus1.wb_busy !== 1'b1 || bus1.in_ready !== 1'b0) begin
            bad++; $display("FAIL rstwr_busy: got busy=%b rdy=%b want 1/0", bus1.wb_busy, bus1.in_ready);
        end
        tick();
        rst = 1'b0; ra = 4'd15; rb = 4'd2;
        #1;
        total++;
        if (bus1.rd_data_a !== 16'h0000 || bus1.rd_data_b !== 16'h0000) begin
            bad++; $display("FAIL rstwr_regs: got %h/%h want 0000/0000", bus1.rd_data_a, bus1.rd_data_b);
        end
        total++;
        if (bus1.wb_busy !== 1'b0 || bus1.in_ready !== 1'b1) begin
            bad++; $display("FAIL rstwr_idle: got busy=%b rdy=%b want 0/1", bus1.wb_busy, bus1.in_ready);
        end
        tick();
        #1;
        total++;
        if (bus1.rd_data_a !== 16'h0000) begin bad++; $display("FAIL rstwr_no_late_write: got %h want 0000", bus1.rd_data_a); end
        tick();
    endtask

    task automatic test_back_to_back();
        int acc;
        acc = 0;
        valid = 1'b1; opc = 4'b0100; dest = 4'd5;
        for (int i = 0; i < 20; i++) begin
            out = 16'($urandom); r15 = 16'($urandom);
            #1;
            if (bus1.in_ready === 1'b1) acc++;
            tick();
        end
        total++;
        if (acc !== 10) begin bad++; $display("FAIL b2b_muldiv_rate: got %0d want 10", acc); end
        while (pend.size() > 0) tick();
        acc = 0;
        opc = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            out = 16'($urandom);
            #1;
            if (bus1.in_ready === 1'b1) acc++;
            tick();
        end
        total++;
        if (acc !== 20) begin bad++; $display("FAIL b2b_addsub_rate: got %0d want 20", acc); end
        valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [3:0] ops [4];
        bit         accepted;
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0100; ops[3] = 4'b0101;
        accepted = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (accepted || !valid) begin
                valid = ($urandom_range(0, 3) != 0);
                opc   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : ops[$urandom_range(0, 3)];
                dest  = 4'($urandom);
                out   = 16'($urandom);
                r15   = 16'($urandom);
                neg   = 1'($urandom);
                zero  = 1'($urandom);
                err   = 1'($urandom);
            end
            ra = 4'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom);
            #1;
            total++;
            if (bus1.in_ready !== exp_ready() || bus1.wb_busy !== (pend.size() != 0)) begin
                bad++; $display("FAIL rand_hs[%0d]: got rdy=%b busy=%b want %b/%b", i,
                                bus1.in_ready, bus1.wb_busy, exp_ready(), (pend.size() != 0));
            end
            total++;
            if ({bus1.flag_neg, bus1.flag_zero, bus1.flag_error} !== mflags) begin
                bad++; $display("FAIL rand_flags[%0d]: got %b want %b", i,
                                {bus1.flag_neg, bus1.flag_zero, bus1.flag_error}, mflags);
            end
            total++;
            if (bus1.rd_data_a !== exp_rd(ra, 1'b1) || bus1.rd_data_b !== exp_rd(rb, 1'b1)) begin
                bad++; $display("FAIL rand_rd_r0z[%0d]: got %h/%h want %h/%h", i,
                                bus1.rd_data_a, bus1.rd_data_b, exp_rd(ra, 1'b1), exp_rd(rb, 1'b1));
            end
            total++;
            if (bus0.rd_data_a !== exp_rd(ra, 1'b0) || bus0.rd_data_b !== exp_rd(rb, 1'b0)) begin
                bad++; $display("FAIL rand_rd_r0reg[%0d]: got %h/%h want %h/%h", i,
                                bus0.rd_data_a, bus0.rd_data_b, exp_rd(ra, 1'b0), exp_rd(rb, 1'b0));
            end
            accepted = valid && exp_ready();
            tick();
        end
        valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_conflict();
        test_r0();
        test_reset_wrhi();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
